stacked_controller: RTL
=======================

// Module: stacked_controller
// PURPOSE
// Moore FSM that sequences the stacked 8-queen datapath. Runs an iterative backtracking search:
// queens are placed row by row, each candidate is checked against all earlier rows, and the
// search backtracks through the position stack. On success it streams the board onto out_bus.
// It sits beside the datapath and drives its control inputs from the datapath status outputs.
// PARAMETERS
// OUT_HOLD  1  cycles enable_output is held per row during readout (>=1)
// PORTS
// clk                input   1  system clock, rising edge
// reset              input   1  asynchronous, active-high; forces IDLE
// start              input   1  begin search; sampled only in IDLE
// cout               input   1  column incrementer carry (column wrapped past 7)
// down_counter_zero  input   1  other-queen row counter == 0
// row_zero           input   1  stack-top row == 0
// last_row           input   1  stack-top row == 7
// last_column        input   1  stack-top column == 7
// safe               input   1  top queen not attacked by queen at counter row
// stack_ready        input   1  stack idle, can take push/pop
// underflow          input   1  stack empty after last pop
// enable_output      output  1  drive top row's one-hot column onto out_bus
// register_load      output  1  write top queen into its row register
// count              output  1  decrement other-queen row counter
// load_counter       output  1  load counter with top row - 1
// push               output  1  push candidate position (1-cycle pulse)
// pop                output  1  pop stack top (1-cycle pulse)
// increament_row     output  1  candidate = (row+1, col 0)
// increament_column  output  1  candidate = (row, col+1)
// ready              output  1  idle, start accepted
// done               output  1  1-cycle pulse, search/readout finished
// solution_found     output  1  valid with done: 1 = board streamed, 0 = exhausted
// BEHAVIOUR
// - All outputs are decoded from state only. Reset value: ready=1, all others 0.
// - Stack rule: push/pop is pulsed only while stack_ready=1, then FSM waits in S_WAIT until stack_ready=1.
//   push+pop together = replace top (one op).
// - IDLE: ready=1; start -> INIT. start in any other state ignored.
// - INIT: push (0,0) with both incrementers off. -> WAIT -> CHECK.
// - CHECK: row_zero -> ACCEPT; else load_counter -> SCAN.
// - SCAN (1 cycle/row): !safe -> NEXTCOL.
//   safe & down_counter_zero -> ACCEPT.
//   safe & !zero -> count, stay.
// - ACCEPT: register_load. last_row -> OUT; else push + increament_row -> WAIT -> CHECK.
// - NEXTCOL: !last_column -> push+pop+increament_column (replace) -> WAIT -> CHECK.
//   last_column -> BACK.
// - BACK: pop -> WAIT. underflow -> FAIL; else -> NEXTCOL (advance previous row's queen).
// - OUT: enable_output for OUT_HOLD cycles, then pop -> WAIT. underflow -> FIN; else OUT.
//   Rows are emitted 7 down to 0.
// - FIN: done=1, solution_found=1, 1 cycle -> IDLE. FAIL: done=1, solution_found=0, 1 cycle -> IDLE.
// - cout while increament_column is high is an error.
//   It cannot occur because last_column is checked first. FSM treats it as last_column (-> BACK).
// - Reset mid-operation: state -> IDLE immediately. Stack and registers are reset by the same reset.
// - Unused state encodings -> IDLE.
// TESTING
// T1 reset asserted mid-SCAN -> same cycle ready=1, push=pop=count=0; next start restarts from INIT.
// T2 start with real datapath -> done with solution_found=1. out_bus in order:
//    08,02,40,04,20,80,10,01 (cols 3,1,6,2,5,7,4,0 = solution 0,4,7,5,2,6,1,3).
// T3 datapath model with safe=0 forever -> row 0 exhausts cols 0..7.
//    Final pop underflows -> done=1, solution_found=0, 0 register_load for rows >0.
// T4 hold stack_ready low 3 cycles after each push -> no further push/pop/register_load until it rises.
//    Same final board as T2.
// T5 pulse start every cycle during search -> search unaffected, exactly one done pulse.
// T6 OUT_HOLD=3 -> each out_bus value stable exactly 3 cycles with enable_output=1, 8 values total.

Source files
------------

// File: rtl/stacked_controller_if.sv
// Control/status bundle between the 8-queen sequencing FSM and its stacked datapath.
// master = controller side, slave = datapath side.
interface stacked_controller_if;
  logic start;
  logic cout;
  logic down_counter_zero;
  logic row_zero;
  logic last_row;
  logic last_column;
  logic safe;
  logic stack_ready;
  logic underflow;
  logic enable_output;
  logic register_load;
  logic count;
  logic load_counter;
  logic push;
  logic pop;
  logic increament_row;
  logic increament_column;
  logic ready;
  logic done;
  logic solution_found;

  modport master (
    input  start, cout, down_counter_zero, row_zero, last_row, last_column,
           safe, stack_ready, underflow,
    output enable_output, register_load, count, load_counter, push, pop,
           increament_row, increament_column, ready, done, solution_found
  );

  modport slave (
    output start, cout, down_counter_zero, row_zero, last_row, last_column,
           safe, stack_ready, underflow,
    input  enable_output, register_load, count, load_counter, push, pop,
           increament_row, increament_column, ready, done, solution_found
  );
endinterface

// File: rtl/stacked_controller.sv
// Moore sequencer for the stacked 8-queen datapath: backtracking search, then
// streams the solved board one row per OUT_HOLD-cycle window.
module stacked_controller #(
  parameter int OUT_HOLD = 1
) (
  input logic                  clk,
  input logic                  reset,
  stacked_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_CHK, S_CHECK, S_SCAN, S_ACCEPT, S_PUSH_ROW, S_NEXTCOL,
    S_REPLACE, S_BACK, S_WAIT_BACK, S_OUT, S_OUT_POP, S_WAIT_OUT, S_FIN, S_FAIL
  } state_t;

  typedef struct packed {
    logic enable_output;
    logic register_load;
    logic count;
    logic load_counter;
    logic push;
    logic pop;
    logic increament_row;
    logic increament_column;
    logic ready;
    logic done;
    logic solution_found;
  } ctl_t;

  localparam int                HOLD_W    = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OUT_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  ctl_t              ctl_q, ctl_d;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_IDLE:     c.ready = 1'b1;
      S_INIT:     c.push = 1'b1;
      S_CHECK:    c.load_counter = 1'b1;
      S_SCAN:     c.count = 1'b1;
      S_ACCEPT:   c.register_load = 1'b1;
      S_PUSH_ROW: begin c.push = 1'b1; c.increament_row = 1'b1; end
      S_REPLACE:  begin c.push = 1'b1; c.pop = 1'b1; c.increament_column = 1'b1; end
      S_BACK:     c.pop = 1'b1;
      S_OUT:      c.enable_output = 1'b1;
      S_OUT_POP:  c.pop = 1'b1;
      S_FIN:      begin c.done = 1'b1; c.solution_found = 1'b1; end
      S_FAIL:     c.done = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Every stack op is followed by a wait state, so push/pop states are only
  // ever entered while the stack is idle.
  always_comb begin
    state_d = state_q;
    hold_d  = (state_q == S_OUT) ? hold_q + 1'b1 : '0;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = S_INIT;
      S_INIT:      state_d = S_WAIT_CHK;
      S_WAIT_CHK:  if (bus.stack_ready) state_d = S_CHECK;
      S_CHECK:     state_d = bus.row_zero ? S_ACCEPT : S_SCAN;
      S_SCAN: begin
        if (!bus.safe)                  state_d = S_NEXTCOL;
        else if (bus.down_counter_zero) state_d = S_ACCEPT;
      end
      S_ACCEPT:    state_d = bus.last_row ? S_OUT : S_PUSH_ROW;
      S_PUSH_ROW:  state_d = S_WAIT_CHK;
      // A column carry is treated exactly like the last column.
      S_NEXTCOL:   state_d = (bus.last_column || bus.cout) ? S_BACK : S_REPLACE;
      S_REPLACE:   state_d = S_WAIT_CHK;
      S_BACK:      state_d = S_WAIT_BACK;
      S_WAIT_BACK: if (bus.stack_ready) state_d = bus.underflow ? S_FAIL : S_NEXTCOL;
      S_OUT:       if (hold_q == HOLD_LAST) state_d = S_OUT_POP;
      S_OUT_POP:   state_d = S_WAIT_OUT;
      S_WAIT_OUT:  if (bus.stack_ready) state_d = bus.underflow ? S_FIN : S_OUT;
      S_FIN:       state_d = S_IDLE;
      S_FAIL:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    ctl_d = decode(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      ctl_q   <= decode(S_IDLE);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.enable_output     = ctl_q.enable_output;
  assign bus.register_load     = ctl_q.register_load;
  assign bus.count             = ctl_q.count;
  assign bus.load_counter      = ctl_q.load_counter;
  assign bus.push              = ctl_q.push;
  assign bus.pop               = ctl_q.pop;
  assign bus.increament_row    = ctl_q.increament_row;
  assign bus.increament_column = ctl_q.increament_column;
  assign bus.ready             = ctl_q.ready;
  assign bus.done              = ctl_q.done;
  assign bus.solution_found    = ctl_q.solution_found;

endmodule
